vc_scheduler: RTL
=================

VC_SCHEDULER -- requirements
Module: vc_scheduler

Interface
REQ-001 Parameter WORD_SIZE, default 6, SHALL set the word width; bit 5 is the VC tag and bit 4 the destination select.
REQ-002 Parameter WEIGHT, default 3, SHALL set the maximum consecutive VC0 grants while VC1 is eligible (range 1..7).
REQ-003 Parameter CNT_W, default 5, SHALL set the width of the per-destination word counters.
REQ-004 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 init  in  1  synchronous clear of counters and arbitration state.
REQ-007 active  in  1  high enables scheduling; driven by the control state machine's active output.
REQ-008 vc0_empty, vc1_empty  in  1 each  VC FIFO empty flags.
REQ-009 vc0_data, vc1_data  in  WORD_SIZE each  show-ahead head word of each VC FIFO, valid when the matching empty flag is low.
REQ-010 pause_d0, pause_d1  in  1 each  destination FIFO almost-full flags.
REQ-011 pop_vc0, pop_vc1  out  1 each  combinational pop strobes to the VC FIFOs.
REQ-012 push_d0, push_d1  out  1 each  registered push strobes to the destination FIFOs.
REQ-013 data_out  out  WORD_SIZE  registered word to the destination FIFOs.
REQ-014 state  out  2  FSM state: 00 IDLE, 01 SERVE_VC0, 10 SERVE_VC1.
REQ-015 cnt_d0, cnt_d1  out  CNT_W each  words pushed to D0 and D1.
REQ-016 idle  out  1  registered; high when no grant occurs and both VCs are empty.

Function
REQ-017 Eligibility SHALL be elig_vcN = active & ~init & ~vcN_empty & ~pause_d[vcN_data[4]].
REQ-018 When only one VC is eligible, that VC SHALL be granted in the same cycle.
REQ-019 When both VCs are eligible, VC0 SHALL be granted if streak < WEIGHT; otherwise VC1 SHALL be granted.
REQ-020 The 3-bit streak counter SHALL increment on a VC0 grant while elig_vc1 is high, saturating at WEIGHT.
REQ-021 The streak counter SHALL clear on any VC1 grant, and on any cycle where elig_vc1 is low.
REQ-022 pop_vcN SHALL equal grant_vcN; at most one pop SHALL be asserted per cycle.
REQ-023 The cycle after a grant, data_out SHALL equal the granted head word, and exactly one push_d[word[4]] SHALL be high for one cycle (latency 1).
REQ-024 Without a grant, push_d0 and push_d1 SHALL be low and data_out SHALL hold its last value.
REQ-025 cnt_dX SHALL increment on each push_dX cycle and wrap from 2^CNT_W-1 to 0.
REQ-026 FSM next state: SERVE_VC0 on a VC0 grant, SERVE_VC1 on a VC1 grant, IDLE on no grant.
REQ-027 A pause flag asserting on the grant cycle SHALL be honoured: no grant to that destination in that cycle; a word already registered SHALL still push.
REQ-028 A pause change for one destination SHALL NOT block a VC whose head word targets the other destination.
REQ-029 init high SHALL clear cnt_d0, cnt_d1 and streak, force state IDLE, and suppress grants, while still completing a push registered in the previous cycle.
REQ-030 active low SHALL suppress new grants only; counters SHALL hold.

Reset
REQ-031 While reset is high, all registers SHALL clear: data_out 0, push_d0/d1 0, cnt_d0/d1 0, streak 0, state IDLE, idle 1.
REQ-032 While reset is high, pop_vc0 and pop_vc1 SHALL be 0.
REQ-033 Reset asserted mid-transfer SHALL discard any pending registered push without emitting it.

Verification
REQ-034 active=1, VC0 only holds 0x05 (dest 0), no pause -> pop_vc0 at cycle N; push_d0=1, data_out=0x05 at N+1; cnt_d0=1.
REQ-035 Both VCs continuously eligible, WEIGHT=3 -> grant sequence VC0,VC0,VC0,VC1 repeating; state follows 01,01,01,10.
REQ-036 pause_d1=1, VC0 head 0x12 (dest 1), VC1 head 0x20 (dest 0) -> only VC1 popped; push_d0=1, data_out=0x20.
REQ-037 CNT_W=5, 32 words to D0 -> cnt_d0 wraps to 0 after the 32nd push.
REQ-038 Reset pulse on the cycle after a grant -> no push emitted; all outputs at reset values; pops low during reset.
REQ-039 init pulse with a push pending -> that push completes; counters read 0 the cycle after init; no pop while init=1.

Source files
------------

// File: rtl/vc_scheduler.sv
// ---------------------------------------------------------------------------
// vc_scheduler
//
// Weighted two-way scheduler that moves words from two virtual-channel (VC)
// FIFOs into two destination FIFOs. Each head word carries its VC tag in
// bit 5 and its destination select in bit 4. VC0 is favoured: it may win up
// to WEIGHT consecutive grants while VC1 is also eligible, after which VC1
// gets one grant. A VC whose head word targets a paused destination is not
// eligible, so it cannot block the other VC.
//
// Handshake: o_pop_vcN is a combinational strobe that acts as "ready" for
// the show-ahead head word, which is valid whenever i_vcN_empty is low; the
// word is consumed on the rising edge where the pop is high. One cycle
// later the word appears on o_data_out with exactly one o_push_dX high for
// that single cycle (i_pause_dX acts as back-pressure sampled before grant).
//
// Ports
//   i_clk, i_reset           clock, asynchronous active-high reset
//   i_init                   synchronous clear of counters/arbitration
//   i_active                 enables scheduling
//   i_vc0_empty/i_vc1_empty  VC FIFO empty flags
//   i_vc0_data/i_vc1_data    VC FIFO head words
//   i_pause_d0/i_pause_d1    destination FIFO almost-full flags
//   o_pop_vc0/o_pop_vc1      combinational pop strobes
//   o_push_d0/o_push_d1      registered push strobes
//   o_data_out               registered word to the destinations
//   o_state                  FSM state (00 IDLE, 01 SERVE_VC0, 10 SERVE_VC1)
//   o_cnt_d0/o_cnt_d1        wrapping counts of words pushed per destination
//   o_idle                   registered: no grant and both VCs empty
// ---------------------------------------------------------------------------
module vc_scheduler #(
   parameter int WORD_SIZE = 6,
   parameter int WEIGHT    = 3,
   parameter int CNT_W     = 5
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_init,
   input  logic                 i_active,
   input  logic                 i_vc0_empty,
   input  logic                 i_vc1_empty,
   input  logic [WORD_SIZE-1:0] i_vc0_data,
   input  logic [WORD_SIZE-1:0] i_vc1_data,
   input  logic                 i_pause_d0,
   input  logic                 i_pause_d1,
   output logic                 o_pop_vc0,
   output logic                 o_pop_vc1,
   output logic                 o_push_d0,
   output logic                 o_push_d1,
   output logic [WORD_SIZE-1:0] o_data_out,
   output logic [1:0]           o_state,
   output logic [CNT_W-1:0]     o_cnt_d0,
   output logic [CNT_W-1:0]     o_cnt_d1,
   output logic                 o_idle
);

   localparam int       DEST_BIT = 4;
   localparam logic [2:0] WEIGHT_L = 3'(WEIGHT);

   typedef enum logic [1:0] {
      IDLE      = 2'b00,
      SERVE_VC0 = 2'b01,
      SERVE_VC1 = 2'b10
   } state_t;

   state_t                 r_state;
   state_t                 w_next_state;
   logic [2:0]             r_streak;
   logic                   r_push_d0;
   logic                   r_push_d1;
   logic [WORD_SIZE-1:0]   r_data_out;
   logic [CNT_W-1:0]       r_cnt_d0;
   logic [CNT_W-1:0]       r_cnt_d1;
   logic                   r_idle;

   logic                   w_pause_vc0;
   logic                   w_pause_vc1;
   logic                   w_elig_vc0;
   logic                   w_elig_vc1;
   logic                   w_grant_vc0;
   logic                   w_grant_vc1;
   logic                   w_grant;
   logic [WORD_SIZE-1:0]   w_grant_word;
   logic                   w_grant_dest;

   // Each VC looks at the pause flag of the destination its head word targets.
   assign w_pause_vc0 = i_vc0_data[DEST_BIT] ? i_pause_d1 : i_pause_d0;
   assign w_pause_vc1 = i_vc1_data[DEST_BIT] ? i_pause_d1 : i_pause_d0;

   // Reset is folded in so the pops stay low while reset is held.
   assign w_elig_vc0 = i_active & ~i_init & ~i_vc0_empty & ~w_pause_vc0 & ~i_reset;
   assign w_elig_vc1 = i_active & ~i_init & ~i_vc1_empty & ~w_pause_vc1 & ~i_reset;

   // Arbitration and next-state.
   always_comb begin
      w_grant_vc0  = 1'b0;
      w_grant_vc1  = 1'b0;
      w_next_state = IDLE;
      if (w_elig_vc0 && (!w_elig_vc1 || (r_streak < WEIGHT_L))) begin
         w_grant_vc0  = 1'b1;
         w_next_state = SERVE_VC0;
      end else if (w_elig_vc1) begin
         w_grant_vc1  = 1'b1;
         w_next_state = SERVE_VC1;
      end
   end

   assign w_grant      = w_grant_vc0 | w_grant_vc1;
   assign w_grant_word = w_grant_vc1 ? i_vc1_data : i_vc0_data;
   assign w_grant_dest = w_grant_word[DEST_BIT];

   // FSM state register. init suppresses grants, so next state is IDLE then.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else if (i_init) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Datapath, counters and streak.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_push_d0  <= 1'b0;
         r_push_d1  <= 1'b0;
         r_data_out <= '0;
         r_cnt_d0   <= '0;
         r_cnt_d1   <= '0;
         r_streak   <= '0;
         r_idle     <= 1'b1;
      end else begin
         r_push_d0 <= w_grant & ~w_grant_dest;
         r_push_d1 <= w_grant &  w_grant_dest;
         if (w_grant) begin
            r_data_out <= w_grant_word;
         end
         r_idle <= ~w_grant & i_vc0_empty & i_vc1_empty;

         // Counters advance together with the push they count, so the
         // count visible alongside a push already includes that word.
         if (i_init) begin
            r_cnt_d0 <= '0;
            r_cnt_d1 <= '0;
         end else begin
            if (w_grant && !w_grant_dest) begin
               r_cnt_d0 <= r_cnt_d0 + 1'b1;
            end
            if (w_grant && w_grant_dest) begin
               r_cnt_d1 <= r_cnt_d1 + 1'b1;
            end
         end

         // Streak only accumulates while VC1 is actually competing.
         if (i_init || w_grant_vc1 || !w_elig_vc1) begin
            r_streak <= '0;
         end else if (w_grant_vc0 && (r_streak != WEIGHT_L)) begin
            r_streak <= r_streak + 3'd1;
         end
      end
   end

   assign o_pop_vc0  = w_grant_vc0;
   assign o_pop_vc1  = w_grant_vc1;
   assign o_push_d0  = r_push_d0;
   assign o_push_d1  = r_push_d1;
   assign o_data_out = r_data_out;
   assign o_state    = r_state;
   assign o_cnt_d0   = r_cnt_d0;
   assign o_cnt_d1   = r_cnt_d1;
   assign o_idle     = r_idle;

endmodule
